// File: rtl/sc_backg_pkg.sv
// Shared definitions for the background timer and the background state machine.
// Holds:
//  - the timer FSM state encoding;
//  - the speed level codes;
//  - the default terminal periods that the timer and the background FSM top both use.
package sc_backg_pkg;

  // The state register is 4 bits wide so that the background FSM can share the encoding space.
  typedef enum logic [3:0] {
    RESET_0 = 4'd0,
    RUN_0   = 4'd1,
    TC_0    = 4'd2,
    PAUSE_0 = 4'd3
  } timerStateType;

  // Speed level codes: level 0 scrolls slowest, level 3 scrolls fastest.
  localparam logic [1:0] LEVEL_0 = 2'd0;
  localparam logic [1:0] LEVEL_1 = 2'd1;
  localparam logic [1:0] LEVEL_2 = 2'd2;
  localparam logic [1:0] LEVEL_3 = 2'd3;

  // Default number of increments per terminal count at each level.
  localparam int DEFAULT_DATAWIDTH_COUNT = 23;
  localparam int DEFAULT_PERIOD_L0       = 5000000;
  localparam int DEFAULT_PERIOD_L1       = 3500000;
  localparam int DEFAULT_PERIOD_L2       = 2000000;
  localparam int DEFAULT_PERIOD_L3       = 1000000;

endpackage

// File: rtl/sc_backg_period_sel.sv
// Combinational lookup from the level currently in force to its terminal period.
// Ports:
//  SC_BACKGPERIODSEL_level_In    in   2                level currently in force
//  SC_BACKGPERIODSEL_period_Out  out  DATAWIDTH_COUNT  increments per terminal count at that level
module sc_backg_period_sel
  import sc_backg_pkg::*;
#(
  parameter int DATAWIDTH_COUNT = DEFAULT_DATAWIDTH_COUNT,
  parameter int PERIOD_L0       = DEFAULT_PERIOD_L0,
  parameter int PERIOD_L1       = DEFAULT_PERIOD_L1,
  parameter int PERIOD_L2       = DEFAULT_PERIOD_L2,
  parameter int PERIOD_L3       = DEFAULT_PERIOD_L3
) (
  input  logic [1:0]                 SC_BACKGPERIODSEL_level_In,
  output logic [DATAWIDTH_COUNT-1:0] SC_BACKGPERIODSEL_period_Out
);

  // Straight table lookup; each level code selects one period.
  always_comb begin
    SC_BACKGPERIODSEL_period_Out = DATAWIDTH_COUNT'(PERIOD_L0);
    case (SC_BACKGPERIODSEL_level_In)
      LEVEL_0: SC_BACKGPERIODSEL_period_Out = DATAWIDTH_COUNT'(PERIOD_L0);
      LEVEL_1: SC_BACKGPERIODSEL_period_Out = DATAWIDTH_COUNT'(PERIOD_L1);
      LEVEL_2: SC_BACKGPERIODSEL_period_Out = DATAWIDTH_COUNT'(PERIOD_L2);
      LEVEL_3: SC_BACKGPERIODSEL_period_Out = DATAWIDTH_COUNT'(PERIOD_L3);
      default: SC_BACKGPERIODSEL_period_Out = DATAWIDTH_COUNT'(PERIOD_L0);
    endcase
  end

endmodule

// File: rtl/sc_backg_timer.sv
// Programmable event timer that feeds the background state machine.
// It counts the FSM's active-low strobe and pulls T0 low at each terminal count.
// The terminal period depends on the speed level, which is taken from level_In only at clear or at wrap.
// Ports:
//  SC_BACKGTIMER_CLOCK_50       in   1                system clock, 50 MHz
//  SC_BACKGTIMER_RESET_InHigh   in   1                asynchronous reset, active-high
//  SC_BACKGTIMER_upcount_InLow  in   1                count enable, one increment per low cycle
//  SC_BACKGTIMER_clear_InLow    in   1                synchronous clear, active-low
//  SC_BACKGTIMER_level_In       in   2                requested speed level
//  SC_BACKGTIMER_pause_InHigh   in   1                freeze timer
//  SC_BACKGTIMER_T0_OutLow      out  1                terminal-count flag, active-low, registered
//  SC_BACKGTIMER_count_Out      out  DATAWIDTH_COUNT  current count value
//  SC_BACKGTIMER_level_Out      out  2                level currently in force
module sc_backg_timer
  import sc_backg_pkg::*;
#(
  parameter int DATAWIDTH_COUNT = DEFAULT_DATAWIDTH_COUNT,
  parameter int PERIOD_L0       = DEFAULT_PERIOD_L0,
  parameter int PERIOD_L1       = DEFAULT_PERIOD_L1,
  parameter int PERIOD_L2       = DEFAULT_PERIOD_L2,
  parameter int PERIOD_L3       = DEFAULT_PERIOD_L3
) (
  input  logic                       SC_BACKGTIMER_CLOCK_50,
  input  logic                       SC_BACKGTIMER_RESET_InHigh,
  input  logic                       SC_BACKGTIMER_upcount_InLow,
  input  logic                       SC_BACKGTIMER_clear_InLow,
  input  logic [1:0]                 SC_BACKGTIMER_level_In,
  input  logic                       SC_BACKGTIMER_pause_InHigh,
  output logic                       SC_BACKGTIMER_T0_OutLow,
  output logic [DATAWIDTH_COUNT-1:0] SC_BACKGTIMER_count_Out,
  output logic [1:0]                 SC_BACKGTIMER_level_Out
);

  localparam logic [DATAWIDTH_COUNT-1:0] countOne = DATAWIDTH_COUNT'(1);

  timerStateType              timerState;
  logic                       pausedFromTc;
  logic [DATAWIDTH_COUNT-1:0] periodSel;
  logic [DATAWIDTH_COUNT-1:0] lastCount;

  sc_backg_period_sel #(
    .DATAWIDTH_COUNT(DATAWIDTH_COUNT),
    .PERIOD_L0      (PERIOD_L0),
    .PERIOD_L1      (PERIOD_L1),
    .PERIOD_L2      (PERIOD_L2),
    .PERIOD_L3      (PERIOD_L3)
  ) uPeriodSel (
    .SC_BACKGPERIODSEL_level_In  (SC_BACKGTIMER_level_Out),
    .SC_BACKGPERIODSEL_period_Out(periodSel)
  );

  assign lastCount = periodSel - countOne;

  // The FSM, counter and T0 flag all sit in one register block.
  // Clear beats pause, and pause beats upcount.
  // In the terminal increment the wrap compare uses >=, so the count cannot
  // pass the last value even if the register were corrupted.
  // A level change only takes effect at a wrap, so a running period is never shortened.
  always_ff @(posedge SC_BACKGTIMER_CLOCK_50 or posedge SC_BACKGTIMER_RESET_InHigh) begin
    if (SC_BACKGTIMER_RESET_InHigh) begin
      timerState              <= RESET_0;
      pausedFromTc            <= 1'b0;
      SC_BACKGTIMER_count_Out <= '0;
      SC_BACKGTIMER_T0_OutLow <= 1'b1;
      SC_BACKGTIMER_level_Out <= LEVEL_0;
    end else if (timerState == RESET_0) begin
      SC_BACKGTIMER_level_Out <= SC_BACKGTIMER_level_In;
      timerState              <= RUN_0;
    end else if (!SC_BACKGTIMER_clear_InLow) begin
      SC_BACKGTIMER_count_Out <= '0;
      SC_BACKGTIMER_T0_OutLow <= 1'b1;
      SC_BACKGTIMER_level_Out <= SC_BACKGTIMER_level_In;
      pausedFromTc            <= 1'b0;
      timerState              <= RUN_0;
    end else begin
      case (timerState)
        PAUSE_0: begin
          if (!SC_BACKGTIMER_pause_InHigh) begin
            timerState <= pausedFromTc ? TC_0 : RUN_0;
          end
        end
        RUN_0: begin
          if (SC_BACKGTIMER_pause_InHigh) begin
            pausedFromTc <= 1'b0;
            timerState   <= PAUSE_0;
          end else if (!SC_BACKGTIMER_upcount_InLow) begin
            if (SC_BACKGTIMER_count_Out >= lastCount) begin
              SC_BACKGTIMER_count_Out <= '0;
              SC_BACKGTIMER_T0_OutLow <= 1'b0;
              SC_BACKGTIMER_level_Out <= SC_BACKGTIMER_level_In;
              timerState              <= TC_0;
            end else begin
              SC_BACKGTIMER_count_Out <= SC_BACKGTIMER_count_Out + countOne;
            end
          end
        end
        TC_0: begin
          if (SC_BACKGTIMER_pause_InHigh) begin
            pausedFromTc <= 1'b1;
            timerState   <= PAUSE_0;
          end else if (!SC_BACKGTIMER_upcount_InLow) begin
            SC_BACKGTIMER_count_Out <= SC_BACKGTIMER_count_Out + countOne;
            SC_BACKGTIMER_T0_OutLow <= 1'b1;
            timerState              <= RUN_0;
          end
        end
        default: timerState <= RESET_0;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_backg_timer.sv
// Scoreboard bench for sc_backg_timer using small periods (4,3,2,2) and a 3-bit counter.
// The stimulus side advances a behavioural model each cycle and queues the expected outputs.
// A monitor pops one entry after every rising edge and compares it with the DUT.
module tb_sc_backg_timer;

  typedef struct {
    int cnt;
    bit t0Low;
    int lvl;
  } expType;

  logic       clock;
  logic       reset;
  logic       upcountLow;
  logic       clearLow;
  logic [1:0] levelIn;
  logic       pauseHigh;
  logic       t0Low;
  logic [2:0] countOut;
  logic [1:0] levelOut;

  expType expQueue[$];
  int     checks;
  int     failures;

  // Behavioural model: a terminal is "pending" from the wrap until the next strobe.
  int periodTable[4] = '{4, 3, 2, 2};
  int modelCount;
  int modelLevel;
  bit modelPending;
  bit modelPaused;
  bit modelInReset;

  sc_backg_timer #(
    .DATAWIDTH_COUNT(3),
    .PERIOD_L0      (4),
    .PERIOD_L1      (3),
    .PERIOD_L2      (2),
    .PERIOD_L3      (2)
  ) dut (
    .SC_BACKGTIMER_CLOCK_50     (clock),
    .SC_BACKGTIMER_RESET_InHigh (reset),
    .SC_BACKGTIMER_upcount_InLow(upcountLow),
    .SC_BACKGTIMER_clear_InLow  (clearLow),
    .SC_BACKGTIMER_level_In     (levelIn),
    .SC_BACKGTIMER_pause_InHigh (pauseHigh),
    .SC_BACKGTIMER_T0_OutLow    (t0Low),
    .SC_BACKGTIMER_count_Out    (countOut),
    .SC_BACKGTIMER_level_Out    (levelOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    modelCount   = 0;
    modelLevel   = 0;
    modelPending = 1'b0;
    modelPaused  = 1'b0;
    modelInReset = 1'b1;
  endtask

  // Advance the model by one clock edge, applying clear > pause > upcount.
  task automatic modelStep(input bit up, input bit clr, input bit pau, input int lvl);
    if (modelInReset) begin
      modelLevel   = lvl;
      modelInReset = 1'b0;
    end else if (!clr) begin
      modelCount   = 0;
      modelPending = 1'b0;
      modelPaused  = 1'b0;
      modelLevel   = lvl;
    end else if (modelPaused) begin
      if (!pau) modelPaused = 1'b0;
    end else if (pau) begin
      modelPaused = 1'b1;
    end else if (!up) begin
      if (modelPending) begin
        modelCount   = modelCount + 1;
        modelPending = 1'b0;
      end else if (modelCount + 1 == periodTable[modelLevel]) begin
        modelCount   = 0;
        modelPending = 1'b1;
        modelLevel   = lvl;
      end else begin
        modelCount = modelCount + 1;
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
  task automatic applyStimulus(input bit up, input bit clr, input bit pau, input int lvl);
    expType e;
    @(negedge clock);
    reset      = 1'b0;
    upcountLow = up;
    clearLow   = clr;
    pauseHigh  = pau;
    levelIn    = 2'(lvl);
    modelStep(up, clr, pau, lvl);
    e.cnt   = modelCount;
    e.t0Low = !modelPending;
    e.lvl   = modelLevel;
    expQueue.push_back(e);
  endtask

  // Assert reset between edges and confirm the outputs react without a clock.
  task automatic asyncReset();
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("asyncCount", int'(countOut), 0);
    checkOutput("asyncT0", int'(t0Low), 1);
    checkOutput("asyncLevel", int'(levelOut), 0);
    modelReset();
  endtask

  // Monitor: every rising edge yields one observable result.
  always @(posedge clock) begin
    expType e;
    #1;
    if (expQueue.size() > 0) begin
      e = expQueue.pop_front();
      checkOutput("count", int'(countOut), e.cnt);
      checkOutput("t0Low", int'(t0Low), int'(e.t0Low));
      checkOutput("level", int'(levelOut), e.lvl);
    end
  end

  initial begin
    int wait_cycles;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    upcountLow = 1'b1;
    clearLow   = 1'b1;
    pauseHigh  = 1'b0;
    levelIn    = 2'd0;
    modelReset();
    #12;
    checkOutput("resetCount", int'(countOut), 0);
    checkOutput("resetT0", int'(t0Low), 1);
    checkOutput("resetLevel", int'(levelOut), 0);

    // Continuous upcount at level 0, covering two full periods.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0);

    // Strobe every third cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 36; i++) applyStimulus((i % 3) != 0, 1'b1, 1'b0, 0);

    // Level change mid-period.
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3);

    // Pause while T0 is low.
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b1, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);

    // Clear coincident with the terminal increment.
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 2);

    // Async reset mid-period, then resume counting.
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    asyncReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(2, 0) == 0, $urandom_range(15, 0) != 0,
                    $urandom_range(7, 0) == 0, int'($urandom_range(3, 0)));
    end

    wait_cycles = 0;
    while (expQueue.size() > 0 && wait_cycles < 20) begin
      @(posedge clock);
      wait_cycles++;
    end
    #2;
    checkOutput("queueDrained", expQueue.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
